// File: rtl/regfile_pkg.sv
// regfile_pkg
//   Shared sizing constants and types for the register-file storage block.
//   NUM_REGS must be a power of two and at least 4. ADDR_W follows from it.
//   reg_word_t : one architectural register value.
//   reg_addr_t : register index.
package regfile_pkg;

    localparam int NUM_REGS = 32;
    localparam int WIDTH    = 64;
    localparam int ZERO_REG = 31;
    localparam int ADDR_W   = $clog2(NUM_REGS);

    typedef logic [WIDTH-1:0]  reg_word_t;
    typedef logic [ADDR_W-1:0] reg_addr_t;

endpackage

// File: rtl/reg_en.sv
// reg_en
//   One W-bit storage register with load enable and synchronous reset,
//   built as W independent D flip-flops.
//   Ports:
//     clk   - rising-edge clock
//     reset - synchronous active-high clear (wins over en)
//     en    - load d on the next rising edge
//     d     - data to load
//     q     - current register contents
module reg_en #(
    parameter int W = regfile_pkg::WIDTH
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    for (genvar gi = 0; gi < W; gi++) begin : g_bit
        // Each bit gets its own flop so the storage maps onto one DFF per bit.
        logic q_reg;

        always_ff @(posedge clk) begin
            if (reset) begin
                q_reg <= 1'b0;
            end else if (en) begin
                q_reg <= d[gi];
            end
        end

        assign q[gi] = q_reg;
    end

endmodule

// File: rtl/reg_bank.sv
// reg_bank
//   Storage half of the CPU register file: NUM_REGS x WIDTH registers with a
//   single synchronous write port. All register contents are exposed in
//   parallel for the downstream read-select mux trees. Register ZERO_REG is
//   a constant zero; writes to it are dropped and not counted.
//   Ports:
//     clk           - rising-edge clock
//     reset         - synchronous active-high; clears all registers and
//                     write_count, and overrides a same-cycle write
//     RegWrite      - write enable
//     WriteRegister - destination register index
//     WriteData     - value to write
//     regs_out      - packed array, regs_out[i] = contents of register i
//     write_count   - committed writes since reset, wraps at 16 bits
module reg_bank
    import regfile_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      RegWrite,
    input  reg_addr_t                 WriteRegister,
    input  reg_word_t                 WriteData,
    output reg_word_t [NUM_REGS-1:0]  regs_out,
    output logic [15:0]               write_count
);

    // One-hot write enables; bit ZERO_REG is tied low so a write there
    // neither stores nor counts.
    logic [NUM_REGS-1:0] wr_en;
    logic [15:0]         write_count_reg;

    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
        if (gi == ZERO_REG) begin : g_zero
            assign wr_en[gi]    = 1'b0;
            assign regs_out[gi] = '0;
        end else begin : g_live
            // RegWrite gates the compare first, so an unknown index while
            // RegWrite is low still yields a clean 0 enable.
            assign wr_en[gi] = RegWrite && (WriteRegister == reg_addr_t'(gi));

            reg_en #(
                .W (WIDTH)
            ) u_reg (
                .clk   (clk),
                .reset (reset),
                .en    (wr_en[gi]),
                .d     (WriteData),
                .q     (regs_out[gi])
            );
        end
    end

    // A write commits exactly when some live register enable is high.
    always_ff @(posedge clk) begin
        if (reset) begin
            write_count_reg <= '0;
        end else if (|wr_en) begin
            write_count_reg <= write_count_reg + 16'd1;
        end
    end

    assign write_count = write_count_reg;

endmodule
